// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle restoring divider for the ALU DIV operation.
//
// A start pulse in IDLE latches dividend/divisor. The sequencer then computes
// one quotient bit per clock (WIDTH iterations), applies a sign fix-up, and
// registers quotient -> lo_out and remainder -> hi_out for the HI/LO load.
// Sequence: IDLE -> LOAD -> ITER (WIDTH cycles) -> FIX -> DONE -> IDLE.
// A zero divisor skips ITER/FIX: LOAD -> DONE with lo_out = all ones,
// hi_out = dividend, div_by_zero = 1.
//
// Build option: define DIV_SIGNED_EN for a two's-complement divide. The
// quotient truncates toward zero and the remainder takes the dividend's sign.
// When DIV_SIGNED_EN is undefined the divide is unsigned only, and FIX is a
// plain register-transfer cycle.
//
// Ports:
//   clock        in   rising-edge clock
//   clear        in   synchronous active-high reset, overrides everything
//   start        in   request pulse, sampled only in IDLE
//   dividend     in   [WIDTH] numerator, latched on an accepted start
//   divisor      in   [WIDTH] denominator, latched on an accepted start
//   busy         out  high in LOAD, ITER and FIX
//   done         out  one-cycle pulse, results valid
//   div_by_zero  out  set with done when the divisor was 0; held until next start
//   lo_out       out  [WIDTH] quotient, held until the next result or clear
//   hi_out       out  [WIDTH] remainder, held until the next result or clear

module div_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] hi_out
);

    localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ITER,
        FIX,
        DONE
    } state_t;

    state_t state, state_d;

    logic [WIDTH-1:0] a_q;      // latched dividend
    logic [WIDTH-1:0] b_q;      // latched divisor, replaced by its magnitude in LOAD
    logic [WIDTH-1:0] q_q;      // quotient shift register
    logic [WIDTH-1:0] p_q;      // partial remainder
    logic [CW-1:0]    cnt_q;    // iteration counter

    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

`ifdef DIV_SIGNED_EN
    logic sign_q;
    logic sign_r;
`endif

    // The restored remainder is always below the divisor, so it fits in WIDTH
    // bits. Only the shifted value needs the extra bit, which feeds the
    // WIDTH+1-bit trial subtraction.
    always_comb begin
        p_shift = {p_q, q_q[WIDTH-1]};
        trial   = p_shift - {1'b0, b_q};
`ifdef DIV_SIGNED_EN
        a_mag = a_q[WIDTH-1] ? -a_q : a_q;
        b_mag = b_q[WIDTH-1] ? -b_q : b_q;
        q_fix = sign_q ? -q_q : q_q;
        r_fix = sign_r ? -p_q : p_q;
`else
        a_mag = a_q;
        b_mag = b_q;
        q_fix = q_q;
        r_fix = p_q;
`endif
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        busy    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                busy    = 1'b1;
                state_d = (b_q == '0) ? DONE : ITER;
            end
            ITER: begin
                busy = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // done and div_by_zero are registered off the DONE state. The pulse
    // therefore appears one edge after DONE is entered, which gives the
    // WIDTH+3 edge (normal) and 2 edge (divide-by-zero) latencies.
    always_ff @(posedge clock) begin
        if (clear) begin
            a_q         <= '0;
            b_q         <= '0;
            q_q         <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            lo_out      <= '0;
            hi_out      <= '0;
`ifdef DIV_SIGNED_EN
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
`endif
        end else begin
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q         <= dividend;
                        b_q         <= divisor;
                        div_by_zero <= 1'b0;
                    end
                end
                LOAD: begin
                    if (b_q == '0) begin
                        lo_out <= '1;
                        hi_out <= a_q;
                    end else begin
                        p_q   <= '0;
                        q_q   <= a_mag;
                        b_q   <= b_mag;
                        cnt_q <= '0;
`ifdef DIV_SIGNED_EN
                        sign_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
                        sign_r <= a_q[WIDTH-1];
`endif
                    end
                end
                ITER: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (trial[WIDTH]) begin
                        p_q <= p_shift[WIDTH-1:0];
                        q_q <= {q_q[WIDTH-2:0], 1'b0};
                    end else begin
                        p_q <= trial[WIDTH-1:0];
                        q_q <= {q_q[WIDTH-2:0], 1'b1};
                    end
                end
                FIX: begin
                    lo_out <= q_fix;
                    hi_out <= r_fix;
                end
                DONE: begin
                    // b_q still holds the divisor (or its non-zero magnitude)
                    div_by_zero <= (b_q == '0);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         clear;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] lo_out;
    logic [W-1:0] hi_out;

    always #5 clock = ~clock;

    div_sequencer #(.WIDTH(W)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .lo_out      (lo_out),
        .hi_out      (hi_out)
    );

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dbz;
        int           lat;
        int           busy_cyc;
        int           issue;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic on the operand values.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   sa;
        int   sb_i;
        e.a     = a;
        e.b     = b;
        e.issue = 0;
        if (b == 0) begin
            e.lo       = '1;
            e.hi       = a;
            e.dbz      = 1'b1;
            e.lat      = 2;
            e.busy_cyc = 1;
        end else begin
            e.dbz      = 1'b0;
            e.lat      = W + 3;
            e.busy_cyc = W + 2;
`ifdef DIV_SIGNED_EN
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.lo = 32'h8000_0000;
                e.hi = '0;
            end else begin
                sa   = a;
                sb_i = b;
                e.lo = sa / sb_i;
                e.hi = sa % sb_i;
            end
`else
            sa   = 0;
            sb_i = 0;
            e.lo = a / b;
            e.hi = a % b;
`endif
        end
        return e;
    endfunction

    // Monitor: pops one expectation per done pulse.
    always @(negedge clock) begin
        if (clear) begin
            busy_cnt = 0;
        end else if (busy) begin
            busy_cnt++;
        end
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending request (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("lo %0h/%0h", mon_e.a, mon_e.b), lo_out, mon_e.lo);
                check($sformatf("hi %0h/%0h", mon_e.a, mon_e.b), hi_out, mon_e.hi);
                check($sformatf("dbz %0h/%0h", mon_e.a, mon_e.b), W'(div_by_zero), W'(mon_e.dbz));
                check($sformatf("latency %0h/%0h", mon_e.a, mon_e.b), W'(cyc - mon_e.issue), W'(mon_e.lat));
                check($sformatf("busy_cycles %0h/%0h", mon_e.a, mon_e.b), W'(busy_cnt), W'(mon_e.busy_cyc));
            end
            busy_cnt = 0;
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        exp_t e;
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        if (push) begin
            e       = model(a, b);
            e.issue = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL done_timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b);
        issue(a, b, 1'b1);
        wait_idle();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           mode;

        clear    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clock);
        #1;
        clear = 1'b0;
        check("reset_busy", W'(busy), '0);
        check("reset_done", W'(done), '0);
        check("reset_dbz", W'(div_by_zero), '0);
        check("reset_lo", lo_out, '0);
        check("reset_hi", hi_out, '0);

        run(32'd100, 32'd7);
        run(32'hFFFF_FFFF, 32'd1);
        run(32'd5, 32'd9);
        run(32'd55, 32'd0);
        issue(32'd8, 32'd2, 1'b1);
        check("dbz_cleared_on_start", W'(div_by_zero), '0);
        wait_idle();
        run(32'h8000_0000, 32'hFFFF_FFFF);
        run(32'd0, 32'd3);
        run(32'd3, 32'd3);
`ifdef DIV_SIGNED_EN
        run(-32'sd7, 32'd2);
        run(32'd7, -32'sd2);
        run(-32'sd7, -32'sd2);
        run(32'h8000_0000, 32'd1);
`endif

        // A second start while busy is ignored.
        issue(32'd1000, 32'd3, 1'b1);
        repeat (3) @(posedge clock);
        issue(32'd9, 32'd9, 1'b0);
        wait_idle();

        // A start that lands in the DONE state is dropped.
        issue(32'd6, 32'd3, 1'b1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (!busy) break;
        end
        dividend = 32'd1;
        divisor  = 32'd1;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_idle();
        repeat (45) @(negedge clock);

        // Clear mid-operation discards the divide.
        issue(32'd1000, 32'd3, 1'b0);
        repeat (8) @(posedge clock);
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        check("clear_busy", W'(busy), '0);
        check("clear_lo", lo_out, '0);
        check("clear_hi", hi_out, '0);
        check("clear_done", W'(done), '0);
        repeat (45) @(negedge clock);
        run(32'd12, 32'd4);

        for (int n = 0; n < 40; n++) begin
            a    = $urandom;
            mode = $urandom_range(0, 5);
            case (mode)
                0: b = '0;
                1: b = $urandom_range(1, 15);
                2: b = $urandom;
                3: b = a;
                4: b = $urandom >> $urandom_range(0, 31);
                default: begin
                    a = $urandom_range(0, 1000);
                    b = $urandom;
                end
            endcase
            run(a, b);
        end

        repeat (5) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
